uart_tx_buffered: RTL and testbench

UART transmitter for the 8N1 serial link: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
A small FIFO in front of the transmitter lets the CPU/bus side queue several bytes with a ready/valid handshake.
Sits beside the UART receiver in the RISC-V SoC UART peripheral and drives the board TX pin.
Line idles high (mark).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 75 +++++++
 rtl/uart_tx_buffered.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - FSM state encoding for the transmitter (IDLE/START/DATA/STOP/CLEANUP)
//   - 8N1 frame geometry (data bits, total bits per frame)
//   - line levels: MARK (idle / stop) and SPACE (start)
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CLEANUP = 3'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO queuing bytes ahead of the UART transmitter.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (empties the FIFO)
//   push_i   : write request; ignored while full
//   data_i   : write data
//   pop_i    : read request; ignored while empty
//   data_o   : head entry (valid while empty_o=0)
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : number of stored entries
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Full/empty come from the registered count, so a push into a full FIFO
  // is refused even when a pop frees a slot on the same edge.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with a byte FIFO in front.
//   i_Clock      : system clock, rising edge
//   i_Reset      : asynchronous active-high reset; aborts any frame, empties FIFO
//   i_Tx_DV      : write strobe, byte accepted when i_Tx_DV & o_Tx_Ready
//   i_Tx_Byte    : byte to queue
//   o_Tx_Ready   : FIFO not full
//   o_Tx_Serial  : registered serial line, idles high
//   o_Tx_Active  : high for the 10*CLKS_PER_BIT cycles of a frame
//   o_Tx_Done    : one-cycle pulse after each stop bit
//   o_Fifo_Count : queued bytes, not counting the one being shifted out
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  // CLKS_PER_BIT-1 always fits in $clog2(CLKS_PER_BIT) bits for values >= 2.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (i_Tx_DV),
    .data_i  (i_Tx_Byte),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_Fifo_Count)
  );

  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = done_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = MARK;
        active_d = 1'b0;
        done_d   = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          serial_d = SPACE;
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shift_q[0];
          state_d  = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            serial_d = MARK;
            state_d  = ST_STOP;
          end else begin
            // The shift register keeps the current bit in [0]; the next bit is [1].
            idx_d    = idx_q + 3'd1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        serial_d = MARK;
        active_d = 1'b0;
        done_d   = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= MARK;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are pushed to a scoreboard queue; a monitor pops one per
// frame and compares the sampled line against the expected 8N1 waveform.
module tb_uart_tx_buffered;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int FRAME_CYC = 10 * CPB;
  localparam int START_GAP = FRAME_CYC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [7:0]    byte_i;
  logic          o_Tx_Ready;
  logic          o_Tx_Serial;
  logic          o_Tx_Active;
  logic          o_Tx_Done;
  logic [CW-1:0] o_Fifo_Count;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [7:0] sb_q[$];
  int         starts[$];

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Tx_DV      (dv),
    .i_Tx_Byte    (byte_i),
    .o_Tx_Ready   (o_Tx_Ready),
    .o_Tx_Serial  (o_Tx_Serial),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .o_Fifo_Count (o_Fifo_Count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_Tx_Done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write for one cycle starting at a falling edge.
  task automatic wr(input logic [7:0] b, input logic acc);
    dv     = 1'b1;
    byte_i = b;
    check("ready_at_write", o_Tx_Ready, acc);
    if (acc) sb_q.push_back(b);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (o_Tx_Done === 1'b1) got = 1'b1;
    end
    check(tag, got, 1);
  endtask

  // Frame monitor / scoreboard consumer.
  initial begin : monitor
    logic [7:0]           eb;
    logic [FRAME_CYC-1:0] ser_v, act_v, exp_v;
    bit                   aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && o_Tx_Active === 1'b1) begin
        check("frame_expected", sb_q.size() != 0, 1);
        eb = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
        starts.push_back(cyc);
        for (int k = 0; k < FRAME_CYC; k++) begin
          int b;
          b = k / CPB;
          exp_v[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
        end
        aborted = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          ser_v[k] = o_Tx_Serial;
          act_v[k] = o_Tx_Active;
        end
        if (!aborted) begin
          check("frame_bits", ser_v, exp_v);
          check("frame_active", act_v, {FRAME_CYC{1'b1}});
          @(negedge clk);
          check("done_pulse", {o_Tx_Done, o_Tx_Active, o_Tx_Serial}, 3'b101);
          @(negedge clk);
          check("done_clear", {o_Tx_Done, o_Tx_Active, o_Tx_Serial}, 3'b001);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int s0, d0, d1;
    bit seen;

    rst    = 1'b1;
    dv     = 1'b0;
    byte_i = 8'h00;
    #1;
    check("reset_line", {o_Tx_Serial, o_Tx_Active, o_Tx_Done}, 3'b100);
    check("reset_count", o_Fifo_Count, 0);
    check("reset_ready", o_Tx_Ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, latency and frame shape
    wr(8'hA5, 1'b1);
    check("count_after_write", o_Fifo_Count, 1);
    check("line_before_pop", o_Tx_Serial, 1);
    @(negedge clk);
    check("start_fall", {o_Tx_Serial, o_Tx_Active}, 2'b01);
    check("count_after_pop", o_Fifo_Count, 0);
    wait_done(60, "a5_done");
    repeat (2) @(negedge clk);

    // Data captured at acceptance
    wr(8'h3C, 1'b1);
    byte_i = 8'hFF;
    wait_done(60, "hold_done");
    repeat (2) @(negedge clk);

    // Burst until full, refused write
    s0 = starts.size();
    d0 = done_cnt;
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    wr(8'h04, 1'b1);
    wr(8'h05, 1'b1);
    check("burst_count_full", o_Fifo_Count, 4);
    wr(8'h06, 1'b0);
    check("burst_refused_count", o_Fifo_Count, 4);

    // Write while full on the pop edge is ignored
    wait_done(60, "f01_done");
    @(negedge clk);
    check("full_before_pop", o_Fifo_Count, 4);
    wr(8'h07, 1'b0);
    check("count_after_full_pop", o_Fifo_Count, 3);
    wr(8'h07, 1'b1);
    check("count_refill", o_Fifo_Count, 4);

    // Simultaneous write and pop at count 2
    wait_done(60, "f02_done");
    wait_done(60, "f03_done");
    wait_done(60, "f04_done");
    @(negedge clk);
    check("count_before_wr_pop", o_Fifo_Count, 2);
    wr(8'h08, 1'b1);
    check("count_after_wr_pop", o_Fifo_Count, 2);
    wait_done(60, "f05_done");
    wait_done(60, "f07_done");
    wait_done(60, "f08_done");
    repeat (2) @(negedge clk);
    check("burst_frames", starts.size() - s0, 7);
    check("burst_done_pulses", done_cnt - d0, 7);
    for (int k = s0 + 1; k < starts.size(); k++)
      check("start_spacing", starts[k] - starts[k-1], START_GAP);

    // Reset during data bit 3 (0x52 has bit3=0, so the line is low there)
    wr(8'h52, 1'b1);
    wr(8'hC3, 1'b1);
    repeat (17) @(negedge clk);
    check("pre_reset_line", {o_Tx_Serial, o_Tx_Active}, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_line", {o_Tx_Serial, o_Tx_Active, o_Tx_Done}, 3'b100);
    check("async_reset_count", o_Fifo_Count, 0);
    check("async_reset_ready", o_Tx_Ready, 1);
    sb_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    d1 = done_cnt;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (o_Tx_Active !== 1'b0 || o_Tx_Serial !== 1'b1) seen = 1'b1;
    end
    check("no_frame_after_reset", seen, 0);
    check("no_done_after_reset", done_cnt - d1, 0);

    // Normal operation resumes after reset
    wr(8'h96, 1'b1);
    wait_done(60, "post_reset_done");
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
